// File: rtl/demux4x16_buf.sv
`default_nettype none
// ============================================================================
//  Module   : demux4x16_buf
//  Purpose  : 1-to-4 registered demultiplexer. Each input word is steered by
//             a 2-bit select into one of four single-entry channel buffers,
//             and each buffer hands its word to its consumer via valid/ready.
//             A per-channel counter tallies completed deliveries.
//  Revision : 1.0 - initial release
// ============================================================================
module demux4x16_buf #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic               CLK,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_sel,
   input  logic [WIDTH-1:0]   in_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [WIDTH-1:0]   out_a,
   output logic [WIDTH-1:0]   out_b,
   output logic [WIDTH-1:0]   out_c,
   output logic [WIDTH-1:0]   out_d,
   output logic [4*CNT_W-1:0] deliv_cnt
);

   localparam int c_NCH = 4;

   logic [WIDTH-1:0] r_data [c_NCH];
   logic [CNT_W-1:0] r_cnt  [c_NCH];
   logic [c_NCH-1:0] r_full;
   logic [c_NCH-1:0] w_accept;
   logic [c_NCH-1:0] w_drain;

   // A channel can take a word when empty, or when it is being emptied this
   // same cycle, so a consumer holding ready high sees one word per cycle.
   assign in_ready = ~r_full[in_sel] | out_ready[in_sel];

   generate
      for (genvar k = 0; k < c_NCH; k++) begin : g_ch
         assign w_accept[k] = in_valid & in_ready & (in_sel == 2'(k));
         assign w_drain[k]  = r_full[k] & out_ready[k];

         // Channel buffer: a new word wins over a drain, keeping the slot full
         always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
               r_data[k] <= '0;
               r_full[k] <= 1'b0;
            end else if (w_accept[k]) begin
               r_data[k] <= in_data;
               r_full[k] <= 1'b1;
            end else if (w_drain[k]) begin
               r_full[k] <= 1'b0;
            end
         end

         // Delivery counter: one increment per completed handoff, free-running wrap
         always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt[k] <= '0;
            end else if (w_drain[k]) begin
               r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
         end

         assign deliv_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
      end
   endgenerate

   assign out_valid = r_full;
   assign out_a     = r_data[0];
   assign out_b     = r_data[1];
   assign out_c     = r_data[2];
   assign out_d     = r_data[3];

endmodule
`default_nettype wire

// File: tb/tb_demux4x16_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux4x16_buf
//  Purpose  : Self-checking bench for demux4x16_buf: directed scenarios plus
//             randomized traffic against a per-channel behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux4x16_buf;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         in_sel;
   logic [WIDTH-1:0]   in_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [WIDTH-1:0]   out_a, out_b, out_c, out_d;
   logic [4*CNT_W-1:0] deliv_cnt;

   int checks = 0;
   int errors = 0;

   // behavioural model: what each consumer-facing slot holds
   bit        m_full [4];
   int        m_data [4];
   int        m_cnt  [4];

   demux4x16_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .CLK       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_d     (out_d),
      .deliv_cnt (deliv_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] chan_out(input int k);
      case (k)
         0:       return out_a;
         1:       return out_b;
         2:       return out_c;
         default: return out_d;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_full[k] = 1'b0;
         m_data[k] = 0;
         m_cnt[k]  = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = m_full[k];
      chk({tag, ".valid"}, out_valid, ev);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s.data%0d", tag, k), chan_out(k), m_data[k]);
         chk($sformatf("%s.cnt%0d", tag, k), deliv_cnt[k*CNT_W +: CNT_W], m_cnt[k]);
      end
   endtask

   // One clock of traffic: apply inputs, check ready, advance model, check state
   task automatic step(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] ordy, input string tag);
      bit exp_rdy;
      @(negedge clk);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = ordy;
      #1;
      exp_rdy = !m_full[s] || ordy[s];
      chk({tag, ".in_ready"}, in_ready, exp_rdy);
      for (int k = 0; k < 4; k++) begin
         if (m_full[k] && ordy[k]) begin
            m_full[k] = 1'b0;
            m_cnt[k]  = (m_cnt[k] + 1) % (1 << CNT_W);
         end
      end
      if (v && exp_rdy) begin
         m_full[s] = 1'b1;
         m_data[s] = d;
      end
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0;
      model_reset();
      #3;
      compare_all("reset");
      chk("reset.in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // routing: one word per channel, nobody consuming
      for (int k = 0; k < 4; k++) step(1'b1, 2'(k), WIDTH'(k), 4'b0000, "route");
      chk("route.all_valid", out_valid, 4'b1111);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_sel = 2'(k);
         #1;
         chk($sformatf("route.blocked%0d", k), in_ready, 1'b0);
      end

      // backpressure on channel 2, then release
      step(1'b1, 2'd2, 16'hBEEF, 4'b0000, "bp_hold");
      chk("bp.out_c_held", out_c, 16'h0002);
      step(1'b1, 2'd2, 16'hBEEF, 4'b0100, "bp_release");
      chk("bp.out_c_new", out_c, 16'hBEEF);

      // streaming into channel 1 with its consumer always ready
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 2'd1, WIDTH'(16'h1000 + i), 4'b0010, "stream");
         chk("stream.out_b", out_b, WIDTH'(16'h1000 + i));
      end
      chk("stream.cnt1", deliv_cnt[1*CNT_W +: CNT_W], 8'd8);

      // counter wrap on channel 3: 256 drains, refilled every cycle
      for (int i = 0; i < 256; i++) step(1'b1, 2'd3, WIDTH'($urandom), 4'b1000, "wrap");
      chk("wrap.cnt3", deliv_cnt[3*CNT_W +: CNT_W], 8'd0);
      chk("wrap.cnt0", deliv_cnt[0*CNT_W +: CNT_W], 8'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 2'($urandom), WIDTH'($urandom), 4'($urandom), "rand");

      // async reset with words buffered, observed before the next edge
      for (int k = 0; k < 4; k++) step(1'b1, 2'(k), WIDTH'($urandom), 4'b0000, "refill");
      chk("arst.pre_valid", out_valid, 4'b1111);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 4'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("arst");
      chk("arst.in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 2'd0, 16'h5A5A, 4'b0000, "post_rst");
      chk("post_rst.out_a", out_a, 16'h5A5A);
      for (int i = 0; i < 100; i++)
         step(1'($urandom), 2'($urandom), WIDTH'($urandom), 4'($urandom), "rand2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
